// File: rtl/rr_bus_arbiter_3_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rr_bus_arbiter_3_if : requester/consumer bus of the 3-way arbiter   |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
interface rr_bus_arbiter_3_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       req;
    logic [2:0]       last;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [2:0]       ack;
    logic [2:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        input  req, last, d0, d1, d2, out_ready,
        output ack, gnt, sel, out_valid, out_data
    );

    modport slave (
        output req, last, d0, d1, d2, out_ready,
        input  ack, gnt, sel, out_valid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/rr_bus_arbiter_3.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rr_bus_arbiter_3 : round-robin burst arbiter with registered output |
// | Optional grant statistics / stall flag under ARB_STATS_EN. Rev 1.0  |
// +---------------------------------------------------------------------+
module rr_bus_arbiter_3 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rr_bus_arbiter_3_if.master bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]        gnt_cnt0,
    output logic [15:0]        gnt_cnt1,
    output logic [15:0]        gnt_cnt2,
    output logic               stall
`endif
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    logic [2:0]       r_gnt;
    logic [1:0]       r_sel;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_can_load;
    logic [2:0]       w_gnt_req;
    logic [2:0]       w_ack;
    logic             w_xfer;
    logic             w_last;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_burst_end;
    logic             w_release;
    logic             w_any_req;
    logic [1:0]       w_c1;
    logic [1:0]       w_c2;
    logic [1:0]       w_c3;
    logic [1:0]       w_pick_idx;
    logic [WIDTH-1:0] w_mux;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] f_onehot(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b001;
        endcase
        return v;
    endfunction

    // A word may enter the output stage when it is empty or draining this cycle.
    assign w_can_load  = !r_out_valid || bus.out_ready;
    assign w_gnt_req   = r_gnt & bus.req;
    assign w_ack       = (r_state == S_GRANT) ? (w_gnt_req & {3{w_can_load}}) : 3'b000;
    assign w_xfer      = |w_ack;
    assign w_last      = |(r_gnt & bus.last);
    assign w_cnt_nxt   = r_cnt + 1'b1;
    assign w_burst_end = (w_cnt_nxt == CNT_W'(MAX_BURST));
    assign w_release   = !(|w_gnt_req) || (w_xfer && (w_last || w_burst_end));
    assign w_any_req   = |bus.req;

    // Search order starts just after the last granted requester.
    assign w_c1 = f_next(r_ptr);
    assign w_c2 = f_next(w_c1);
    assign w_c3 = f_next(w_c2);

    always_comb begin
        w_pick_idx = w_c3;
        if (bus.req[w_c1]) begin
            w_pick_idx = w_c1;
        end else if (bus.req[w_c2]) begin
            w_pick_idx = w_c2;
        end
    end

    always_comb begin
        w_mux = bus.d0;
        case (r_sel)
            2'd1:    w_mux = bus.d1;
            2'd2:    w_mux = bus.d2;
            default: w_mux = bus.d0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gnt       <= 3'b000;
            r_sel       <= 2'd0;
            r_ptr       <= 2'd2;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_mux;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_gnt   <= f_onehot(w_pick_idx);
                        r_sel   <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (w_xfer) begin
                        r_cnt <= w_cnt_nxt;
                    end
                    // Release always lands in IDLE, giving one dead cycle per hand-over.
                    if (w_release) begin
                        r_gnt   <= 3'b000;
                        r_ptr   <= r_sel;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack       = w_ack;
    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

`ifdef ARB_STATS_EN
    logic [15:0] r_gnt_cnt [3];
    logic        w_new_grant;

    assign w_new_grant = (r_state == S_IDLE) && w_any_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                r_gnt_cnt[k] <= 16'h0000;
            end
        end else if (w_new_grant) begin
            for (int k = 0; k < 3; k++) begin
                if ((w_pick_idx == 2'(k)) && (r_gnt_cnt[k] != 16'hFFFF)) begin
                    r_gnt_cnt[k] <= r_gnt_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign gnt_cnt0 = r_gnt_cnt[0];
    assign gnt_cnt1 = r_gnt_cnt[1];
    assign gnt_cnt2 = r_gnt_cnt[2];
    assign stall    = (r_state == S_GRANT) && (|w_gnt_req) && !w_can_load;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_bus_arbiter_3.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_rr_bus_arbiter_3 : vector-table bench with output-word scoreboard |
// | Rev 1.0                                                             |
// +---------------------------------------------------------------------+
module tb_rr_bus_arbiter_3;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_bus_arbiter_3_if #(.WIDTH(WIDTH)) bus ();

`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;
    logic [15:0] gnt_cnt2;
    logic        stall;
`endif

    rr_bus_arbiter_3 #(
        .WIDTH    (WIDTH),
        .MAX_BURST(4),
        .CNT_W    (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef ARB_STATS_EN
        ,
        .gnt_cnt0(gnt_cnt0),
        .gnt_cnt1(gnt_cnt1),
        .gnt_cnt2(gnt_cnt2),
        .stall   (stall)
`endif
    );

    typedef struct packed {
        logic       rst_n;
        logic [2:0] req;
        logic [2:0] last;
        logic       rdy;
        logic [2:0] ack;
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       ov;
    } vec_t;

    vec_t        vt[$];
    logic [31:0] sb[$];
    logic [31:0] base [3];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic add(input logic r, input logic [2:0] rq, input logic [2:0] lst,
                       input logic rd, input logic [2:0] ak, input logic [2:0] gn,
                       input logic [1:0] sl, input logic ov);
        vec_t v;
        v.rst_n = r; v.req = rq; v.last = lst; v.rdy = rd;
        v.ack = ak; v.gnt = gn; v.sel = sl; v.ov = ov;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        base[0] = 32'hA5A5_0000;
        base[1] = 32'h1111_0000;
        base[2] = 32'h2222_0000;

        // single-word burst from requester 0
        add(1, 3'b001, 3'b001, 1, 3'b000, 3'b000, 2'd0, 0);
        add(1, 3'b001, 3'b001, 1, 3'b001, 3'b001, 2'd0, 0);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd0, 1);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);
        add(0, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);
        // all requesting: 4-word bursts, order 0,1,2,0
        add(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);
        add(1, 3'b111, 3'b000, 1, 3'b001, 3'b001, 2'd0, 0);
        repeat (3) add(1, 3'b111, 3'b000, 1, 3'b001, 3'b001, 2'd0, 1);
        add(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd0, 1);
        add(1, 3'b111, 3'b000, 1, 3'b010, 3'b010, 2'd1, 0);
        repeat (3) add(1, 3'b111, 3'b000, 1, 3'b010, 3'b010, 2'd1, 1);
        add(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd1, 1);
        add(1, 3'b111, 3'b000, 1, 3'b100, 3'b100, 2'd2, 0);
        repeat (3) add(1, 3'b111, 3'b000, 1, 3'b100, 3'b100, 2'd2, 1);
        add(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd2, 1);
        add(1, 3'b111, 3'b000, 1, 3'b001, 3'b001, 2'd0, 0);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b001, 2'd0, 1);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);
        // requester 1 with 3 cycles of backpressure mid-burst
        add(1, 3'b010, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);
        add(1, 3'b010, 3'b000, 1, 3'b010, 3'b010, 2'd1, 0);
        add(1, 3'b010, 3'b000, 1, 3'b010, 3'b010, 2'd1, 1);
        repeat (3) add(1, 3'b010, 3'b000, 0, 3'b000, 3'b010, 2'd1, 1);
        repeat (2) add(1, 3'b010, 3'b000, 1, 3'b010, 3'b010, 2'd1, 1);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd1, 1);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd1, 0);
        // requester 2 drops req after 2 words, pending requester 0 follows
        add(1, 3'b100, 3'b000, 1, 3'b000, 3'b000, 2'd1, 0);
        add(1, 3'b101, 3'b000, 1, 3'b100, 3'b100, 2'd2, 0);
        add(1, 3'b101, 3'b000, 1, 3'b100, 3'b100, 2'd2, 1);
        add(1, 3'b001, 3'b000, 1, 3'b000, 3'b100, 2'd2, 1);
        add(1, 3'b001, 3'b000, 1, 3'b000, 3'b000, 2'd2, 0);
        add(1, 3'b001, 3'b001, 1, 3'b001, 3'b001, 2'd0, 0);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd0, 1);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);
        // reset mid-burst with an unaccepted word, then fresh priority
        add(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);
        add(1, 3'b111, 3'b000, 1, 3'b010, 3'b010, 2'd1, 0);
        add(1, 3'b111, 3'b000, 1, 3'b010, 3'b010, 2'd1, 1);
        add(0, 3'b111, 3'b000, 0, 3'b000, 3'b010, 2'd1, 1);
        add(1, 3'b111, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);
        add(1, 3'b111, 3'b000, 1, 3'b001, 3'b001, 2'd0, 0);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b001, 2'd0, 1);
        add(1, 3'b000, 3'b000, 1, 3'b000, 3'b000, 2'd0, 0);

        rst_n = 1'b0;
        bus.req = 3'b000; bus.last = 3'b000; bus.out_ready = 1'b1;
        bus.d0 = '0; bus.d1 = '0; bus.d2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ack", 32'(bus.ack), 32'h0);
        check("reset gnt", 32'(bus.gnt), 32'h0);
        check("reset sel", 32'(bus.sel), 32'h0);
        check("reset out_valid", 32'(bus.out_valid), 32'h0);
        check("reset out_data", bus.out_data, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < vt.size(); i++) begin
            rst_n         = vt[i].rst_n;
            bus.req       = vt[i].req;
            bus.last      = vt[i].last;
            bus.out_ready = vt[i].rdy;
            bus.d0        = base[0] + 32'(i);
            bus.d1        = base[1] + 32'(i);
            bus.d2        = base[2] + 32'(i);
            @(negedge clk);
            n_vec++;
            check($sformatf("v%0d ack", i), 32'(bus.ack), 32'(vt[i].ack));
            check($sformatf("v%0d gnt", i), 32'(bus.gnt), 32'(vt[i].gnt));
            check($sformatf("v%0d sel", i), 32'(bus.sel), 32'(vt[i].sel));
            check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].ov));
            if (vt[i].ov && vt[i].rdy) begin
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL v%0d scoreboard: got %h expected none queued", i, bus.out_data);
                end else begin
                    check($sformatf("v%0d out_data", i), bus.out_data, sb.pop_front());
                end
            end
            if (!vt[i].rst_n) begin
                sb.delete();
            end else begin
                case (vt[i].ack)
                    3'b001:  sb.push_back(base[0] + 32'(i));
                    3'b010:  sb.push_back(base[1] + 32'(i));
                    3'b100:  sb.push_back(base[2] + 32'(i));
                    default: ;
                endcase
            end
            @(posedge clk); #1;
        end
        check("scoreboard drained", 32'(sb.size()), 32'h0);

`ifdef ARB_STATS_EN
        rst_n = 1'b0; bus.req = 3'b000; bus.last = 3'b000; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.req = 3'b001; bus.last = 3'b001;
        repeat (10) @(posedge clk);
        #1;
        bus.req = 3'b000; bus.last = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        bus.req = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("stall cycle 1", 32'(stall), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall cycle 2", 32'(stall), 32'h1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1; bus.last = 3'b010;
        @(negedge clk);
        check("stall released", 32'(stall), 32'h0);
        @(posedge clk); #1;
        bus.req = 3'b000; bus.last = 3'b000;
        @(posedge clk); #1;
        bus.req = 3'b010; bus.last = 3'b010;
        repeat (2) @(posedge clk);
        #1;
        bus.req = 3'b000; bus.last = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("gnt_cnt0", 32'(gnt_cnt0), 32'd5);
        check("gnt_cnt1", 32'(gnt_cnt1), 32'd2);
        check("gnt_cnt2", 32'(gnt_cnt2), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rr_bus_arbiter_3.md
Name: rr_bus_arbiter_3

Overview:
- Round-robin arbiter and sequencer for the shared 32-bit three-input bus multiplexer.
- Shares one downstream 32-bit consumer among three requesters using valid/ack bursts.
- Drives the mux select; the selected word is captured in a registered output stage with a valid/ready handshake.
- Sits between the three producers and the consumer, such as the writeback/result bus.

Parameters:
- WIDTH, 32: data width of each requester and of the output.
- MAX_BURST, 4: maximum transfers per grant before forced release (1..2^CNT_W-1).
- CNT_W, 3: burst counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- req  input  3  per-requester valid; bit i = requester i.
- last  input  3  per-requester end-of-burst flag; sampled with the transfer.
- d0, d1, d2  input  WIDTH each  requester data words.
- ack  output  3  combinational per-requester transfer acknowledge.
- gnt  output  3  registered one-hot grant; all zero when idle.
- sel  output  2  registered mux select: 00 = d0, 01 = d1, 10 = d2; never 11.
- out_valid  output  1  registered output word valid.
- out_data  output  WIDTH  registered output word.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, gnt=000, sel=00, out_valid=0, out_data=0, burst count=0, rr pointer=2, so requester 0 has highest priority first.
- Reset mid-burst discards the burst and any unaccepted out_data.
- States:
  - IDLE: if req!=0, choose the first requester with req set, searching from pointer+1 modulo 3. At the same edge, set gnt one-hot, sel=index, count=0, and go to GRANT. If req=0, remain in IDLE with gnt=000; sel holds its last value.
  - GRANT: can_load = !out_valid || out_ready. ack[i] = gnt[i] & req[i] & can_load; the other ack bits are 0.
- Transfer (ack[i]=1): out_data <= word selected by sel, out_valid <= 1, count <= count+1.
- Release from GRANT to IDLE at the edge where any of the following holds:
  - a transfer occurs with last[i]=1;
  - a transfer makes count reach MAX_BURST;
  - the granted req[i] is low.
- On release: gnt <= 000, pointer <= granted index, count <= 0.
- Exactly one dead cycle in IDLE between consecutive grants.
- Output stage:
  - If out_valid && out_ready with no new transfer, out_valid <= 0.
  - If out_valid && !out_ready, out_data and out_valid hold and ack stays 0 (backpressure; the burst stalls and the grant is kept).
  - Simultaneous accept and load: out_data is replaced and out_valid stays 1. Full throughput is 1 word per cycle inside a burst.
- Requests that arrive during GRANT wait; a non-granted requester never receives ack.
- Round-robin fairness: with all three requesting continuously, grant order is 0,1,2,0,...
- Latency: req rises in IDLE -> gnt/sel at the next edge -> first ack in that GRANT cycle -> out_valid at the following edge. Minimum req-to-out_valid is 2 cycles.
- Count wrap is impossible: release at MAX_BURST precedes overflow.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds output gnt_cnt0, gnt_cnt1, gnt_cnt2 (16 bits each), counting grants issued per requester.
  - Counters saturate at 16'hFFFF and clear on reset.
  - Adds output stall (1 bit) = GRANT && gnt&req != 0 && !can_load.
- Not defined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then req=001, d0=32'hA5A5_0001, last=001, out_ready=1 -> gnt=001 and sel=00 after 1 edge; ack[0]=1 that cycle; out_valid=1 and out_data=A5A5_0001 next edge; gnt=000 and state IDLE.
- req=111 held, last=000, out_ready=1 -> bursts of exactly 4 words each; grant order 0,1,2,0 with sel 00,01,10,00; one dead cycle between bursts.
- Requester 1 alone, out_ready low for 3 cycles mid-burst -> out_data holds, ack=000, gnt stays 010; on out_ready=1, transfers resume with no word lost or duplicated.
- Requester 2 granted, req[2] dropped after 2 words -> release the next edge; pointer=2; a pending req[0] is granted next.
- rst_n low mid-burst with out_valid=1 -> next edge: out_valid=0, gnt=000, sel=00; the first post-reset grant goes to requester 0 when req=111.
- ARB_STATS_EN: 5 grants to requester 0 and 2 to requester 1 -> gnt_cnt0=5, gnt_cnt1=2, gnt_cnt2=0; stall=1 during each backpressure cycle.
